// File: rtl/pic_region_capture_if.sv
// pic_region_capture_if
//   Bundles the video input stream, the capture request and the region RAM
//   write port of pic_region_capture.
//   Video in : i_hs, i_vs, i_de, i_data[23:0] ({R,G,B})
//   Control  : i_capture_req in; o_busy, o_done, o_abort out
//   RAM write: o_ram_wr_en, o_ram_wr_addr[ADDR_W-1:0], o_ram_wr_data[7:0]
//   Modports : slave = capture block, master = video source / RAM side.
interface pic_region_capture_if #(
    parameter int ADDR_W = 16
);
    logic              i_hs;
    logic              i_vs;
    logic              i_de;
    logic [23:0]       i_data;
    logic              i_capture_req;
    logic              o_ram_wr_en;
    logic [ADDR_W-1:0] o_ram_wr_addr;
    logic [7:0]        o_ram_wr_data;
    logic              o_busy;
    logic              o_done;
    logic              o_abort;

    modport slave (
        input  i_hs, i_vs, i_de, i_data, i_capture_req,
        output o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data, o_busy, o_done, o_abort
    );

    modport master (
        output i_hs, i_vs, i_de, i_data, i_capture_req,
        input  o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data, o_busy, o_done, o_abort
    );
endinterface

// File: rtl/pic_region_capture.sv
// pic_region_capture
//   Captures one frame's OSD_WIDTH x OSD_HEIGHT window of the incoming video
//   on request, converts each pixel to 8-bit gray and writes it sequentially
//   into the region RAM read back by the overlay path.
//   pclk  : pixel clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pic_region_capture_if.slave (video in, request, RAM write, status)
//   Pixel at cycle n produces its RAM write at cycle n+2.
module pic_region_capture #(
    parameter int OSD_WIDTH  = 256,
    parameter int OSD_HEIGHT = 256,
    parameter int X_START    = 650,
    parameter int Y_START    = 362,
    parameter int ADDR_W     = 16
) (
    input  logic                   pclk,
    input  logic                   rst_n,
    pic_region_capture_if.slave    bus
);

    localparam logic [12:0]       X_LO      = 13'(X_START);
    localparam logic [12:0]       X_HI      = 13'(X_START + OSD_WIDTH);
    localparam logic [12:0]       Y_LO      = 13'(Y_START);
    localparam logic [12:0]       Y_HI      = 13'(Y_START + OSD_HEIGHT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OSD_WIDTH * OSD_HEIGHT - 1);
    localparam logic [11:0]       CNT_MAX   = 12'hFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE
    } state_t;

    // Luma weights sum to 256, so the 16-bit sum never overflows and the
    // gray value is a plain truncation of the top byte.
    function automatic logic [7:0] gray_trunc(input logic [15:0] sum);
        return sum[15:8];
    endfunction

    // hsync is carried for interface symmetry only.
    logic hs_unused;
    assign hs_unused = bus.i_hs;

    logic        vs_d;
    logic        de_d;
    logic [11:0] x_cnt;
    logic [11:0] y_cnt;
    logic        frame_start;
    logic        line_end;
    logic        in_win;

    assign frame_start = vs_d & ~bus.i_vs;
    assign line_end    = de_d & ~bus.i_de;

    // x_cnt/y_cnt hold the position of the pixel currently on i_data.
    assign in_win = bus.i_de
                  & ({1'b0, x_cnt} >= X_LO) & ({1'b0, x_cnt} < X_HI)
                  & ({1'b0, y_cnt} >= Y_LO) & ({1'b0, y_cnt} < Y_HI);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d  <= 1'b0;
            de_d  <= 1'b0;
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            vs_d <= bus.i_vs;
            de_d <= bus.i_de;
            if (bus.i_de) begin
                x_cnt <= (x_cnt == CNT_MAX) ? x_cnt : x_cnt + 12'd1;
            end else begin
                x_cnt <= '0;
            end
            if (frame_start) begin
                y_cnt <= '0;
            end else if (line_end) begin
                y_cnt <= (y_cnt == CNT_MAX) ? y_cnt : y_cnt + 12'd1;
            end
        end
    end

    // ---- stage 1: weighted products and window flag ----
    logic [15:0] prod_r_p1;
    logic [15:0] prod_g_p1;
    logic [15:0] prod_b_p1;
    logic        vld_p1;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_win;
        end
    end

    always_ff @(posedge pclk) begin
        prod_r_p1 <= 16'(bus.i_data[23:16]) * 16'd77;
        prod_g_p1 <= 16'(bus.i_data[15:8])  * 16'd150;
        prod_b_p1 <= 16'(bus.i_data[7:0])   * 16'd29;
    end

    logic [15:0] sum_p1;
    assign sum_p1 = prod_r_p1 + prod_g_p1 + prod_b_p1;

    // ---- stage 2: capture FSM, RAM write and status pulses ----
    state_t            state_q,   state_nxt;
    logic [ADDR_W-1:0] addr_q,    addr_nxt;
    logic              vld_p2,    vld_nxt;
    logic [ADDR_W-1:0] wr_addr_p2, wr_addr_nxt;
    logic [7:0]        wr_data_p2;
    logic              done_p2,   done_nxt;
    logic              abort_p2,  abort_nxt;

    always_comb begin
        state_nxt   = state_q;
        addr_nxt    = addr_q;
        vld_nxt     = 1'b0;
        wr_addr_nxt = wr_addr_p2;
        done_nxt    = 1'b0;
        abort_nxt   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_capture_req) begin
                    state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (frame_start) begin
                    state_nxt = ST_CAPTURE;
                    addr_nxt  = '0;
                end
            end
            ST_CAPTURE: begin
                if (vld_p1) begin
                    vld_nxt     = 1'b1;
                    wr_addr_nxt = addr_q;
                    addr_nxt    = addr_q + 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        done_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                // A new frame before the window completed restarts the
                // capture; completion in the same cycle takes precedence.
                if (frame_start && !done_nxt) begin
                    abort_nxt = 1'b1;
                    addr_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            vld_p2     <= 1'b0;
            wr_addr_p2 <= '0;
            wr_data_p2 <= '0;
            done_p2    <= 1'b0;
            abort_p2   <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            addr_q     <= addr_nxt;
            vld_p2     <= vld_nxt;
            wr_addr_p2 <= wr_addr_nxt;
            done_p2    <= done_nxt;
            abort_p2   <= abort_nxt;
            if (vld_nxt) begin
                wr_data_p2 <= gray_trunc(sum_p1);
            end
        end
    end

    assign bus.o_ram_wr_en   = vld_p2;
    assign bus.o_ram_wr_addr = wr_addr_p2;
    assign bus.o_ram_wr_data = wr_data_p2;
    assign bus.o_busy        = (state_q != ST_IDLE);
    assign bus.o_done        = done_p2;
    assign bus.o_abort       = abort_p2;

endmodule

// File: tb/tb_pic_region_capture.sv
// tb_pic_region_capture
//   Directed bench for pic_region_capture on a 10 x 5 active frame with a
//   4 x 2 window at (2,1). A negedge monitor logs every RAM write and status
//   pulse; scenarios compare the logs against hand-computed values.
module tb_pic_region_capture;

    logic pclk;
    logic rst_n;

    pic_region_capture_if #(.ADDR_W(3)) bus ();

    pic_region_capture #(
        .OSD_WIDTH (4),
        .OSD_HEIGHT(2),
        .X_START   (2),
        .Y_START   (1),
        .ADDR_W    (3)
    ) dut (
        .pclk (pclk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---- monitor ----
    logic [2:0] wa[$];
    logic [7:0] wd[$];
    int done_cnt  = 0;
    int done_bad  = 0;
    int abort_cnt = 0;
    int busy_cnt  = 0;

    always @(negedge pclk) begin
        if (bus.o_ram_wr_en) begin
            wa.push_back(bus.o_ram_wr_addr);
            wd.push_back(bus.o_ram_wr_data);
        end
        if (bus.o_done) begin
            done_cnt++;
            if (!(bus.o_ram_wr_en && bus.o_ram_wr_addr == 3'd7) || bus.o_busy) done_bad++;
        end
        if (bus.o_abort) abort_cnt++;
        if (bus.o_busy)  busy_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---- stimulus helpers ----
    int rst_at   = 0;
    int rst_base = 0;
    bit rst_done = 1'b0;

    task automatic cyc(input logic vs, input logic de, input logic [23:0] d, input logic req);
        bus.i_vs          = vs;
        bus.i_hs          = ~de;
        bus.i_de          = de;
        bus.i_data        = d;
        bus.i_capture_req = req;
        @(posedge pclk);
        #1;
    endtask

    function automatic logic [23:0] pix(input int mode, input int x, input int y);
        if (mode == 0) return {8'(x), 8'(y), 8'h00};
        case (x % 4)
            0:       return 24'hFFFFFF;
            1:       return 24'h000000;
            2:       return 24'hFF0000;
            default: return 24'h00FF00;
        endcase
    endfunction

    task automatic do_reset_check();
        rst_n = 1'b0;
        #1;
        check("rst_mid_wr_en",  32'(bus.o_ram_wr_en),   32'd0);
        check("rst_mid_addr",   32'(bus.o_ram_wr_addr), 32'd0);
        check("rst_mid_data",   32'(bus.o_ram_wr_data), 32'd0);
        check("rst_mid_busy",   32'(bus.o_busy),        32'd0);
        check("rst_mid_writes", 32'(wa.size() - rst_base), 32'd3);
        @(posedge pclk);
        @(posedge pclk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input int mode, input int nlines, input int req_line);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 24'h0, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 24'h0, 1'b0);
        for (int y = 0; y < nlines; y++) begin
            for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 24'h0, 1'b0);
            for (int x = 0; x < 10; x++) begin
                if (rst_at > 0 && !rst_done && (wa.size() - rst_base) >= rst_at) begin
                    rst_done = 1'b1;
                    do_reset_check();
                end
                cyc(1'b0, 1'b1, pix(mode, x, y), (y == req_line && x == 0));
            end
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 24'h0, 1'b0);
    endtask

    task automatic request();
        cyc(1'b0, 1'b0, 24'h0, 1'b1);
        check("busy_rise", 32'(bus.o_busy), 32'd1);
        cyc(1'b0, 1'b0, 24'h0, 1'b0);
    endtask

    task automatic check_writes(input string tag, input int base, input logic [7:0] exp_d[8]);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ga, gd;
            ga = (base + i < wa.size()) ? 32'(wa[base + i]) : 32'hDEAD;
            gd = (base + i < wd.size()) ? 32'(wd[base + i]) : 32'hDEAD;
            check($sformatf("%s_addr%0d", tag, i), ga, 32'(i));
            check($sformatf("%s_data%0d", tag, i), gd, 32'(exp_d[i]));
        end
    endtask

    // ---- scenarios ----
    initial begin
        logic [7:0] exp_xy[8];
        logic [7:0] exp_ext[8];
        int wb, db, ab, bb;
        exp_xy  = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h02, 8'h02, 8'h02};
        exp_ext = '{8'h4C, 8'h95, 8'hFF, 8'h00, 8'h4C, 8'h95, 8'hFF, 8'h00};

        rst_n = 1'b0;
        bus.i_vs = 1'b0; bus.i_hs = 1'b1; bus.i_de = 1'b0;
        bus.i_data = 24'h0; bus.i_capture_req = 1'b0;
        #12;
        check("rst_wr_en", 32'(bus.o_ram_wr_en),   32'd0);
        check("rst_addr",  32'(bus.o_ram_wr_addr), 32'd0);
        check("rst_data",  32'(bus.o_ram_wr_data), 32'd0);
        check("rst_busy",  32'(bus.o_busy),        32'd0);
        check("rst_done",  32'(bus.o_done),        32'd0);
        check("rst_abort", 32'(bus.o_abort),       32'd0);
        @(posedge pclk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 24'h0, 1'b0);

        // Basic capture with {x,y,0} coding.
        wb = wa.size(); db = done_cnt; ab = abort_cnt;
        request();
        send_frame(0, 5, -1);
        check("basic_nwr", 32'(wa.size() - wb), 32'd8);
        check_writes("basic", wb, exp_xy);
        check("basic_done",  32'(done_cnt - db),  32'd1);
        check("basic_abort", 32'(abort_cnt - ab), 32'd0);
        check("basic_busy",  32'(bus.o_busy),     32'd0);

        // Gray extremes.
        wb = wa.size(); db = done_cnt;
        request();
        send_frame(1, 5, -1);
        check("ext_nwr", 32'(wa.size() - wb), 32'd8);
        check_writes("ext", wb, exp_ext);
        check("ext_done", 32'(done_cnt - db), 32'd1);

        // Requests in ARMED and CAPTURE are ignored.
        wb = wa.size(); db = done_cnt;
        request();
        cyc(1'b0, 1'b0, 24'h0, 1'b1);
        cyc(1'b0, 1'b0, 24'h0, 1'b0);
        send_frame(0, 5, 1);
        send_frame(0, 5, -1);
        check("ign_nwr",  32'(wa.size() - wb), 32'd8);
        check("ign_done", 32'(done_cnt - db),  32'd1);
        check("ign_busy", 32'(bus.o_busy),     32'd0);

        // Short frame aborts, next frame captures fully.
        wb = wa.size(); db = done_cnt; ab = abort_cnt;
        request();
        send_frame(0, 2, -1);
        check("short_nwr1",  32'(wa.size() - wb), 32'd4);
        check("short_abort0", 32'(abort_cnt - ab), 32'd0);
        send_frame(0, 5, -1);
        check("short_abort", 32'(abort_cnt - ab), 32'd1);
        check("short_nwr",   32'(wa.size() - wb), 32'd12);
        check_writes("short", wb + 4, exp_xy);
        check("short_done",  32'(done_cnt - db),  32'd1);

        // Reset after the third write.
        wb = wa.size(); db = done_cnt; ab = abort_cnt;
        rst_base = wb; rst_at = 3; rst_done = 1'b0;
        request();
        send_frame(0, 5, -1);
        check("rst_seen", 32'(rst_done), 32'd1);
        rst_at = 0;
        send_frame(0, 5, -1);
        check("rstcap_nwr",   32'(wa.size() - wb),  32'd3);
        check("rstcap_done",  32'(done_cnt - db),   32'd0);
        check("rstcap_abort", 32'(abort_cnt - ab),  32'd0);

        // No request: nothing happens.
        wb = wa.size(); bb = busy_cnt;
        for (int f = 0; f < 3; f++) send_frame(0, 5, -1);
        check("noreq_nwr",  32'(wa.size() - wb),  32'd0);
        check("noreq_busy", 32'(busy_cnt - bb),   32'd0);

        check("done_alignment", 32'(done_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pic_region_capture.md
# pic_region_capture

Write-side counterpart to the region overlay display path. It watches the incoming video stream (hs/vs/de/24-bit RGB) and converts the pixels inside a fixed OSD_WIDTH × OSD_HEIGHT window to 8-bit grayscale. It then writes them sequentially into the region RAM that the overlay block reads back. Capture is on request: one request captures one complete frame's window, and completion or abort is reported by single-cycle pulses.

## Interface
Parameters:
- OSD_WIDTH, 256: window width in pixels
- OSD_HEIGHT, 256: window height in lines
- X_START, 650: first window column (0-based active-pixel index)
- Y_START, 362: first window line (0-based active-line index)
- ADDR_W, 16: RAM address width; must satisfy 2^ADDR_W ≥ OSD_WIDTH*OSD_HEIGHT

Ports:
- pclk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_hs  in  1  hsync (unused for counting; accepted for interface symmetry)
- i_vs  in  1  vsync, active-high; frame start = falling edge
- i_de  in  1  data enable
- i_data  in  24  pixel {R[23:16], G[15:8], B[7:0]}
- i_capture_req  in  1  capture request pulse
- o_ram_wr_en  out  1  RAM write strobe
- o_ram_wr_addr  out  ADDR_W  RAM write address
- o_ram_wr_data  out  8  gray pixel
- o_busy  out  1  high in ARMED or CAPTURE
- o_done  out  1  one-cycle pulse: full window written
- o_abort  out  1  one-cycle pulse: frame ended before window complete

## Operation
Position tracking:
- vs_d is a 1-cycle delayed copy of i_vs. frame_start = vs_d & ~i_vs.
- x counter: 0 on the first de-high cycle of a line, +1 per de-high cycle, cleared when de is low.
- y counter: cleared by frame_start, +1 on each de falling edge. Both counters are 12 bits and saturate at 4095.
- in_win = i_de & (X_START ≤ x < X_START+OSD_WIDTH) & (Y_START ≤ y < Y_START+OSD_HEIGHT), evaluated on the current input pixel.

Gray conversion:
- gray = (77*R + 150*G + 29*B) >> 8, using a 16-bit unsigned sum; bits [15:8] are taken, with no rounding.
- Pipeline stage 1 registers the three products and in_win. Stage 2 registers the sum, wr_en and the address.

FSM:
- IDLE: i_capture_req → ARMED. Requests are ignored in every other state.
- ARMED: frame_start → CAPTURE, with the address counter set to 0.
- CAPTURE: each in_win pixel produces one write at the current address, then address +1.
  - After the write at address OSD_WIDTH*OSD_HEIGHT−1: o_done pulse, go to IDLE. Remaining window pixels in that frame are not written.
  - frame_start while in CAPTURE: o_abort pulse, address reset to 0, stay in CAPTURE. The capture restarts in the new frame.
- If the final write and frame_start occur in the same cycle, done wins: o_done pulses, no o_abort, go to IDLE.

## Timing
- Reset values: o_ram_wr_en=0, o_ram_wr_addr=0, o_ram_wr_data=0, o_busy=0, o_done=0, o_abort=0. FSM = IDLE, counters = 0, vs_d = 0.
- Reset asserted mid-capture clears everything immediately. No done or abort pulse is produced.
- Latency: pixel on i_data at cycle n → o_ram_wr_en/addr/data valid at cycle n+2. The write is one cycle wide per pixel, with back-to-back writes across a window row.
- The state check uses in_win at cycle n. Window pixels entering after the done transition do not write, including pixels already in the pipeline.
- o_done is asserted in cycle n+2, together with the final write. o_abort is asserted the cycle after frame_start is sampled.
- o_busy rises the cycle after i_capture_req is sampled in IDLE. It falls in the same cycle o_done is asserted.
- o_ram_wr_addr and o_ram_wr_data hold their last values when o_ram_wr_en=0.

## Test plan
Bench configuration: 10 active pixels × 5 active lines; parameters OSD_WIDTH=4, OSD_HEIGHT=2, X_START=2, Y_START=1, ADDR_W=3.
- Basic capture: req in IDLE, then a full frame with pixel = {x,y,0} coding → 8 writes at addresses 0..7 in order. Data = (77*x + 150*y) >> 8, e.g. (2,1) → 0x01. o_done is high with the write at address 7.
- Gray extremes: window pixels 0xFFFFFF and 0x000000 → data 0xFF and 0x00. 0xFF0000 → 0x4C.
- Request ignored: req pulsed in ARMED and again in CAPTURE → exactly one capture, one o_done, o_busy low afterwards.
- Short frame: frame_start after line 1 (only 4 writes) → o_abort pulse, next frame writes addresses 0..7, then o_done.
- Reset mid-capture: rst_n low after the 3rd write → all outputs 0 at once, no done/abort, next frame produces no writes without a new req.
- No request: three full frames with no req → o_ram_wr_en never asserted, o_busy stays 0.
